pipe_stage_hs: RTL and testbench
================================

# pipe_stage_hs

Parametrised, handshaked pipeline register stage that replaces the fixed-field, always-advancing inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the RV32IM pipeline. It carries an opaque data payload and a separate control bundle through a valid/ready handshake with an optional two-entry skid buffer. It also supports a synchronous flush that inserts a bubble by invalidating contents and zeroing control. Stages are chained by connecting OUT_* of one instance to IN_* of the next; hazard logic drives FLUSH and throttles via OUT_READY.

## Interface
- DATA_W, 72: payload width (e.g. ALU result, store data, rd address, funct3 packed by the instantiating stage).
- CTRL_W, 4: control-bit width (mem write, mem read, reg write enable, data-mem select); these bits are forced to 0 whenever the stage output is invalid.
- SKID_EN, 1: 1 = two-entry skid buffer with registered IN_READY; 0 = single register with combinational IN_READY.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- FLUSH  in  1  synchronous kill of all held entries.
- IN_VALID  in  1  upstream has a valid item.
- IN_READY  out  1  stage will accept an item this cycle.
- IN_DATA  in  DATA_W  upstream payload.
- IN_CTRL  in  CTRL_W  upstream control bits.
- OUT_VALID  out  1  OUT_DATA/OUT_CTRL hold a valid item.
- OUT_READY  in  1  downstream accepts this cycle (0 = stall).
- OUT_DATA  out  DATA_W  head payload.
- OUT_CTRL  out  CTRL_W  head control; 0 when OUT_VALID=0.
- OCCUPANCY  out  2  number of held items (0..2; max 1 when SKID_EN=0).

## Operation
- Fire rules: in_fire = IN_VALID & IN_READY; out_fire = OUT_VALID & OUT_READY.
- Storage: main register (drives OUT_*), skid register (SKID_EN=1 only), each with data, ctrl, and valid fields.
- SKID_EN=1 state machine (state = occupancy):
  - EMPTY: in_fire -> ONE, main <= IN.
  - ONE: in_fire & out_fire -> ONE, main <= IN; in_fire & !out_fire -> FULL, skid <= IN; !in_fire & out_fire -> EMPTY; else hold.
  - FULL: out_fire -> ONE, main <= skid; else hold. in_fire cannot occur.
  - IN_READY = (state != FULL), driven from a flop; no combinational path from OUT_READY.
- SKID_EN=0: IN_READY = !OUT_VALID | OUT_READY (combinational). in_fire loads main; out_fire without in_fire empties it.
- FLUSH (highest priority, both modes): next state EMPTY, all valid bits 0, all ctrl fields 0. Data fields may hold stale values. An in_fire in the same cycle is consumed and discarded. IN_READY is not lowered by FLUSH.
- Control gating: any register whose valid bit is 0 holds ctrl = 0. OUT_CTRL is therefore 0 on every cycle OUT_VALID = 0, so a bubble never writes memory or the register file.
- Ordering: strict FIFO; no item is duplicated or dropped except by FLUSH.
- OCCUPANCY = number of set valid bits.

## Timing
- Reset (async, immediate): OUT_VALID=0, OUT_DATA=0, OUT_CTRL=0, OCCUPANCY=0, skid cleared. IN_READY=1 in both modes.
- Latency: an item accepted at edge N appears on OUT_* after edge N (1 cycle) when the stage is empty or draining.
- Throughput: 1 item/cycle when OUT_READY is held high, in both modes.
- Stall: OUT_READY=0 holds OUT_* bit-stable. With SKID_EN=1, IN_READY drops one cycle after the second item is accepted.
- Release from FULL: the first out_fire returns IN_READY to 1 at the next edge; the skid item appears on OUT_* in the cycle after the main item leaves.
- Simultaneous FLUSH & OUT_READY: the head item counts as delivered this cycle; contents are empty after the edge.
- RST asserted mid-transfer: contents lost, outputs zero asynchronously, no item emitted after deassertion.

## Test plan
- Reset/idle: assert RST with random inputs -> OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, IN_READY=1, OCCUPANCY=0.
- Streaming (both SKID_EN): push 0x01..0x10 back-to-back with OUT_READY=1 -> same sequence out, one per cycle, 1-cycle latency, OCCUPANCY never >1.
- Stall/skid (SKID_EN=1): push A=0xAA, B=0xBB with OUT_READY=0 -> OCCUPANCY=2, IN_READY=0, OUT_DATA=0xAA stable. Raise OUT_READY -> 0xAA, then 0xBB, IN_READY=1 one cycle later, C=0xCC pushed during drain follows B.
- Flush bubble: FULL with ctrl=4'b1111, pulse FLUSH with IN_VALID=1 (D=0xDD) -> next cycle OUT_VALID=0, OUT_CTRL=0, OCCUPANCY=0; D never emerges.
- Control gating: random IN_VALID/OUT_READY/FLUSH for 10k cycles against a scoreboard -> no loss, no duplication, order kept, OUT_CTRL=0 whenever OUT_VALID=0.
- Async reset mid-stall: RST pulse between edges while FULL -> outputs zero before next edge; after release, first item out is the first pushed post-reset.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: handshaked pipeline register stage that carries a data
// payload and a control bundle between pipeline stages.
// With SKID_EN=1 a second (skid) entry lets IN_READY come straight from a
// flop. With SKID_EN=0 a single register is used and IN_READY is combinational.
// The control bits of every empty entry are held at zero, so a bubble can
// never raise a memory or register-file write.
module pipe_stage_hs #(
  parameter int DATA_W  = 72,
  parameter int CTRL_W  = 4,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0] IN_CTRL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [1:0]        OCCUPANCY
);

  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              main_valid;
  logic              in_fire;
  logic              out_fire;

  assign in_fire   = IN_VALID & IN_READY;
  assign out_fire  = main_valid & OUT_READY;
  assign OUT_VALID = main_valid;
  assign OUT_DATA  = main_data;
  assign OUT_CTRL  = main_ctrl;

  if (SKID_EN) begin : g_skid
    typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              skid_valid;
    logic              in_ready_q;

    // Occupancy state machine moving items through main and skid entries;
    // IN_READY is registered so it never depends on OUT_READY in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state      <= EMPTY;
        main_data  <= '0;
        main_ctrl  <= '0;
        main_valid <= 1'b0;
        skid_data  <= '0;
        skid_ctrl  <= '0;
        skid_valid <= 1'b0;
        in_ready_q <= 1'b1;
      end else if (FLUSH) begin
        state      <= EMPTY;
        main_ctrl  <= '0;
        main_valid <= 1'b0;
        skid_ctrl  <= '0;
        skid_valid <= 1'b0;
        in_ready_q <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              state      <= ONE;
              main_data  <= IN_DATA;
              main_ctrl  <= IN_CTRL;
              main_valid <= 1'b1;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_data <= IN_DATA;
              main_ctrl <= IN_CTRL;
            end else if (in_fire) begin
              state      <= FULL;
              skid_data  <= IN_DATA;
              skid_ctrl  <= IN_CTRL;
              skid_valid <= 1'b1;
              in_ready_q <= 1'b0;
            end else if (out_fire) begin
              state      <= EMPTY;
              main_ctrl  <= '0;
              main_valid <= 1'b0;
            end
          end
          FULL: begin
            if (out_fire) begin
              state      <= ONE;
              main_data  <= skid_data;
              main_ctrl  <= skid_ctrl;
              skid_ctrl  <= '0;
              skid_valid <= 1'b0;
              in_ready_q <= 1'b1;
            end
          end
          default: begin
            state      <= EMPTY;
            main_ctrl  <= '0;
            main_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end

    assign IN_READY  = in_ready_q;
    assign OCCUPANCY = {1'b0, main_valid} + {1'b0, skid_valid};
  end else begin : g_direct
    // Single register: a load takes priority; a drain without a load empties it.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        main_data  <= '0;
        main_ctrl  <= '0;
        main_valid <= 1'b0;
      end else if (FLUSH) begin
        main_ctrl  <= '0;
        main_valid <= 1'b0;
      end else if (in_fire) begin
        main_data  <= IN_DATA;
        main_ctrl  <= IN_CTRL;
        main_valid <= 1'b1;
      end else if (out_fire) begin
        main_ctrl  <= '0;
        main_valid <= 1'b0;
      end
    end

    assign IN_READY  = ~main_valid | OUT_READY;
    assign OCCUPANCY = {1'b0, main_valid};
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: drives a skid instance and a direct instance from the
// same inputs and compares both against queue-based reference models.
module tb_pipe_stage_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [71:0] in_data;
  logic [3:0]  in_ctrl;
  logic        out_ready;

  logic        s_in_ready, s_out_valid;
  logic [71:0] s_out_data;
  logic [3:0]  s_out_ctrl;
  logic [1:0]  s_occ;
  logic        n_in_ready, n_out_valid;
  logic [71:0] n_out_data;
  logic [3:0]  n_out_ctrl;
  logic [1:0]  n_occ;

  int n_checks = 0;
  int n_errors = 0;

  // Reference contents, head at index 0, entries packed as {ctrl, data}
  logic [75:0] q_s[$];
  logic [75:0] q_n[$];

  always #5 clk = ~clk;

  pipe_stage_hs #(.DATA_W(72), .CTRL_W(4), .SKID_EN(1'b1)) dut_skid (
    .CLK(clk), .RST(rst), .FLUSH(flush),
    .IN_VALID(in_valid), .IN_READY(s_in_ready), .IN_DATA(in_data), .IN_CTRL(in_ctrl),
    .OUT_VALID(s_out_valid), .OUT_READY(out_ready), .OUT_DATA(s_out_data),
    .OUT_CTRL(s_out_ctrl), .OCCUPANCY(s_occ)
  );

  pipe_stage_hs #(.DATA_W(72), .CTRL_W(4), .SKID_EN(1'b0)) dut_direct (
    .CLK(clk), .RST(rst), .FLUSH(flush),
    .IN_VALID(in_valid), .IN_READY(n_in_ready), .IN_DATA(in_data), .IN_CTRL(in_ctrl),
    .OUT_VALID(n_out_valid), .OUT_READY(out_ready), .OUT_DATA(n_out_data),
    .OUT_CTRL(n_out_ctrl), .OCCUPANCY(n_occ)
  );

  // Acceptance rule: skid stage refuses only when holding two items; the
  // direct stage accepts when empty or when its item leaves this cycle.
  function automatic bit exp_ready(input bit skid, input int size, input bit ordy);
    if (skid) return size < 2;
    return (size == 0) || ordy;
  endfunction

  task automatic check_output(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_one(input string nm, input bit skid, input int size, input logic [75:0] head,
                           input logic rdy, input logic vld, input logic [71:0] dat,
                           input logic [3:0] ctl, input logic [1:0] occ);
    check_output({nm, " valid"}, 76'(vld), 76'(size > 0));
    check_output({nm, " ctrl"}, 76'(ctl), (size > 0) ? 76'(head[75:72]) : 76'(0));
    if (size > 0) check_output({nm, " data"}, 76'(dat), 76'(head[71:0]));
    check_output({nm, " in_ready"}, 76'(rdy), 76'(exp_ready(skid, size, out_ready)));
    check_output({nm, " occupancy"}, 76'(occ), 76'(size));
  endtask

  task automatic check_cycle();
    check_one("skid", 1'b1, q_s.size(), (q_s.size() > 0) ? q_s[0] : 76'(0),
              s_in_ready, s_out_valid, s_out_data, s_out_ctrl, s_occ);
    check_one("direct", 1'b0, q_n.size(), (q_n.size() > 0) ? q_n[0] : 76'(0),
              n_in_ready, n_out_valid, n_out_data, n_out_ctrl, n_occ);
  endtask

  task automatic check_reset_outputs(input string nm);
    check_output({nm, " s_valid"}, 76'(s_out_valid), 76'(0));
    check_output({nm, " s_data"}, 76'(s_out_data), 76'(0));
    check_output({nm, " s_ctrl"}, 76'(s_out_ctrl), 76'(0));
    check_output({nm, " s_ready"}, 76'(s_in_ready), 76'(1));
    check_output({nm, " s_occ"}, 76'(s_occ), 76'(0));
    check_output({nm, " n_valid"}, 76'(n_out_valid), 76'(0));
    check_output({nm, " n_data"}, 76'(n_out_data), 76'(0));
    check_output({nm, " n_ctrl"}, 76'(n_out_ctrl), 76'(0));
    check_output({nm, " n_ready"}, 76'(n_in_ready), 76'(1));
    check_output({nm, " n_occ"}, 76'(n_occ), 76'(0));
  endtask

  // One clock cycle: drive inputs, check outputs against the models, then
  // advance the models by the transfers that happen at the edge.
  task automatic apply_stimulus(input bit v, input logic [71:0] d, input logic [3:0] c,
                                input bit ordy, input bit fl);
    bit in_s, out_s, in_n, out_n;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_cycle();
    in_s  = v && exp_ready(1'b1, q_s.size(), ordy);
    out_s = (q_s.size() > 0) && ordy;
    in_n  = v && exp_ready(1'b0, q_n.size(), ordy);
    out_n = (q_n.size() > 0) && ordy;
    @(posedge clk);
    #1;
    if (fl) begin
      q_s.delete();
      q_n.delete();
    end else begin
      if (out_s) void'(q_s.pop_front());
      if (in_s) q_s.push_back({c, d});
      if (out_n) void'(q_n.pop_front());
      if (in_n) q_n.push_back({c, d});
    end
  endtask

  function automatic logic [71:0] rand_data();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[71:0];
  endfunction

  initial begin
    // Reset with random inputs applied
    rst       = 1'b1;
    flush     = 1'($urandom_range(0, 1));
    in_valid  = 1'($urandom_range(0, 1));
    in_data   = rand_data();
    in_ctrl   = 4'($urandom_range(0, 15));
    out_ready = 1'($urandom_range(0, 1));
    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    check_reset_outputs("reset held");
    rst = 1'b0;
    q_s.delete();
    q_n.delete();

    // Back-to-back streaming of 0x01..0x10, then drain
    for (int i = 1; i <= 16; i++)
      apply_stimulus(1'b1, 72'(i), 4'($urandom_range(0, 15)), 1'b1, 1'b0);
    check_output("stream last skid", 76'(s_out_data), 76'(16));
    check_output("stream last direct", 76'(n_out_data), 76'(16));
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 72'h0, 4'h0, 1'b1, 1'b0);

    // Stall and skid: A, B pushed with the sink stalled
    apply_stimulus(1'b1, 72'hAA, 4'h3, 1'b0, 1'b0);
    apply_stimulus(1'b1, 72'hBB, 4'h5, 1'b0, 1'b0);
    check_output("skid occ full", 76'(s_occ), 76'(2));
    check_output("skid ready low", 76'(s_in_ready), 76'(0));
    check_output("skid head A", 76'(s_out_data), 76'(72'hAA));
    apply_stimulus(1'b0, 72'h0, 4'h0, 1'b0, 1'b0);
    check_output("skid head A stable", 76'(s_out_data), 76'(72'hAA));
    apply_stimulus(1'b0, 72'h0, 4'h0, 1'b1, 1'b0);
    check_output("skid head B", 76'(s_out_data), 76'(72'hBB));
    check_output("skid ready back", 76'(s_in_ready), 76'(1));
    apply_stimulus(1'b1, 72'hCC, 4'h6, 1'b1, 1'b0);
    check_output("skid head C", 76'(s_out_data), 76'(72'hCC));
    apply_stimulus(1'b0, 72'h0, 4'h0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 72'h0, 4'h0, 1'b1, 1'b0);

    // Flush bubble while full, with D offered in the same cycle
    apply_stimulus(1'b1, 72'hE1, 4'hF, 1'b0, 1'b0);
    apply_stimulus(1'b1, 72'hE2, 4'hF, 1'b0, 1'b0);
    apply_stimulus(1'b1, 72'hDD, 4'hF, 1'b0, 1'b1);
    check_output("flush s_valid", 76'(s_out_valid), 76'(0));
    check_output("flush s_ctrl", 76'(s_out_ctrl), 76'(0));
    check_output("flush s_occ", 76'(s_occ), 76'(0));
    check_output("flush n_ctrl", 76'(n_out_ctrl), 76'(0));
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 72'h0, 4'h0, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 10000; i++)
      apply_stimulus($urandom_range(0, 99) < 70, rand_data(), 4'($urandom_range(0, 15)),
                     $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);

    // Asynchronous reset pulse between edges while full
    apply_stimulus(1'b1, 72'h11, 4'h7, 1'b0, 1'b0);
    apply_stimulus(1'b1, 72'h22, 4'h7, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("async rst");
    rst = 1'b0;
    #1;
    q_s.delete();
    q_n.delete();
    apply_stimulus(1'b0, 72'h0, 4'h0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 72'h33, 4'h9, 1'b1, 1'b0);
    check_output("post rst first s", 76'(s_out_data), 76'(72'h33));
    check_output("post rst first n", 76'(n_out_data), 76'(72'h33));
    apply_stimulus(1'b0, 72'h0, 4'h0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 72'h0, 4'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
